// File: rtl/reg_writeback.sv
// Register-file writer: merges ALU and load results into an in-order FIFO and
// retires one registered write per cycle, with per-source pending flags for decode.
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic                       mem_ready,
    output logic                       reg_we,
    output logic [4:0]                 dstreg_num,
    output logic [31:0]                write_value,
    input  logic [4:0]                 chk_rs1,
    input  logic [4:0]                 chk_rs2,
    output logic                       rs1_pending,
    output logic                       rs2_pending,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    rd_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          mem_en;
    logic          alu_en;
    logic          pop;
    logic [PW-1:0] alu_slot;

    // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
    assign mem_ready = occupancy <= OW'(DEPTH - 1);
    assign alu_ready = occupancy <= OW'(DEPTH - 2);

    // rd==0 results complete the handshake but are never queued.
    assign mem_en   = mem_valid & mem_ready & (mem_rd != '0);
    assign alu_en   = alu_valid & alu_ready & (alu_rd != '0);
    assign pop      = occupancy != '0;
    assign alu_slot = wr_ptr + PW'(mem_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            reg_we      <= 1'b0;
            dstreg_num  <= '0;
            write_value <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(mem_en) + PW'(alu_en);
            rd_ptr    <= rd_ptr + PW'(pop);
            occupancy <= occupancy + OW'(mem_en) + OW'(alu_en) - OW'(pop);
            reg_we    <= pop;
            if (pop) begin
                dstreg_num  <= rd_q[rd_ptr];
                write_value <= data_q[rd_ptr];
            end
        end
    end

    // Load is the older instruction, so it takes the first free slot.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            rd_q[wr_ptr]   <= mem_rd;
            data_q[wr_ptr] <= mem_data;
        end
        if (alu_en) begin
            rd_q[alu_slot]   <= alu_rd;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        logic [PW-1:0] off;
        logic          live;
        logic          hit1;
        logic          hit2;
        off  = '0;
        live = 1'b0;
        hit1 = reg_we && (dstreg_num == chk_rs1);
        hit2 = reg_we && (dstreg_num == chk_rs2);
        // An entry is live when its distance from the head is below the count.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off  = PW'(i) - rd_ptr;
            live = OW'(off) < occupancy;
            if (live && (rd_q[i] == chk_rs1)) hit1 = 1'b1;
            if (live && (rd_q[i] == chk_rs2)) hit2 = 1'b1;
        end
        rs1_pending = hit1 && (chk_rs1 != '0);
        rs2_pending = hit2 && (chk_rs2 != '0);
    end

endmodule
